// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared widths, the in-flight tag type and function-code helper
//            for the pipelined issue arbiter.
// Revision : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam int REQ_ID_W = 1;
    localparam int FUNC_W   = 8;
    localparam int OPER_W   = 4;

    // One entry of the in-flight tracking pipe.
    typedef struct packed {
        logic                valid;
        logic [REQ_ID_W-1:0] id;
        logic                illegal;
    } tag_t;

    // A function code is legal only when exactly one bit is set.
    function automatic logic func_is_legal(input logic [FUNC_W-1:0] func);
        return ($countones(func) == 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rr_arbiter_2
// Brief    : Two-way round-robin arbiter with a combinational grant and a
//            last-grant register; requester 0 has priority after reset.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter_2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // 1 when requester 1 won most recently, so requester 0 goes next.
    logic r_last;

    // Grant the lone requester, or the one not served last on a tie; no grant in reset.
    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = r_last ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Remember which requester won the last transfer.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (|grant) begin
            r_last <= grant[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_issue_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pipe_issue_arbiter
// Brief    : Arbitrates two requesters onto a shared fixed-latency ALU/parity
//            datapath and routes each result back to its originator.
//            Optional macro PARITY_CHECK_EN adds a parity re-check of
//            dp_result that raises respN_err on mismatch.
// Revision : 1.0  initial release
// ============================================================================
module pipe_issue_arbiter
    import pipe_ctrl_pkg::*;
#(
    parameter int LATENCY = 2   // issue-to-result cycles, legal 1..8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [FUNC_W-1:0] req0_func,
    input  logic [OPER_W-1:0] req0_a,
    input  logic [OPER_W-1:0] req0_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [FUNC_W-1:0] req1_func,
    input  logic [OPER_W-1:0] req1_a,
    input  logic [OPER_W-1:0] req1_b,
    output logic              req1_ready,
    output logic              dp_valid,
    output logic [FUNC_W-1:0] dp_func,
    output logic [OPER_W-1:0] dp_a,
    output logic [OPER_W-1:0] dp_b,
    input  logic [OPER_W-1:0] dp_result,
    input  logic              dp_parity,
    output logic              resp0_valid,
    output logic [OPER_W-1:0] resp0_data,
    output logic              resp0_parity,
    output logic              resp0_err,
    output logic              resp1_valid,
    output logic [OPER_W-1:0] resp1_data,
    output logic              resp1_parity,
    output logic              resp1_err,
    output logic              busy,
    output logic [7:0]        ops_count
);

    logic [1:0]        w_grant;
    logic              w_xfer;
    logic              w_sel;
    logic [FUNC_W-1:0] w_func;
    logic [OPER_W-1:0] w_a;
    logic [OPER_W-1:0] w_b;
    logic              w_legal;
    logic              w_issue;
    logic              w_par_err;
    logic              w_hit0;
    logic              w_hit1;
    tag_t              w_exit;
    tag_t              r_issue_tag;
    tag_t              r_tags [LATENCY];

    rr_arbiter_2 u_arb (
        .clock (clock),
        .reset (reset),
        .req   ({req1_valid, req0_valid}),
        .grant (w_grant)
    );

    // Grants only go to valid requesters, so any grant is a transfer.
    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];
    assign w_xfer     = |w_grant;
    assign w_sel      = w_grant[1];
    assign w_func     = w_sel ? req1_func : req0_func;
    assign w_a        = w_sel ? req1_a    : req0_a;
    assign w_b        = w_sel ? req1_b    : req0_b;
    assign w_legal    = func_is_legal(w_func);
    assign w_issue    = w_xfer && w_legal;

    // Register the winning op onto the datapath; illegal ops issue nothing but keep a tag.
    always_ff @(posedge clock) begin
        if (reset) begin
            dp_valid    <= 1'b0;
            dp_func     <= '0;
            dp_a        <= '0;
            dp_b        <= '0;
            r_issue_tag <= '0;
        end else begin
            dp_valid            <= w_issue;
            dp_func             <= w_issue ? w_func : '0;
            dp_a                <= w_issue ? w_a    : '0;
            dp_b                <= w_issue ? w_b    : '0;
            r_issue_tag.valid   <= w_xfer;
            r_issue_tag.id      <= REQ_ID_W'(w_sel);
            r_issue_tag.illegal <= w_xfer && !w_legal;
        end
    end

    // Free-running tag pipe aligned so its last stage matches dp_result.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_tags[i] <= '0;
            end
        end else begin
            r_tags[0] <= r_issue_tag;
            for (int i = 1; i < LATENCY; i++) begin
                r_tags[i] <= r_tags[i-1];
            end
        end
    end

    assign w_exit = r_tags[LATENCY-1];
    assign w_hit0 = w_exit.valid && (w_exit.id == REQ_ID_W'(0));
    assign w_hit1 = w_exit.valid && (w_exit.id == REQ_ID_W'(1));

`ifdef PARITY_CHECK_EN
    assign w_par_err = ((^dp_result) != dp_parity);
`else
    assign w_par_err = 1'b0;
`endif

    // Return the exiting result to its requester; outputs read zero when not valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp0_valid  <= 1'b0;
            resp0_data   <= '0;
            resp0_parity <= 1'b0;
            resp0_err    <= 1'b0;
            resp1_valid  <= 1'b0;
            resp1_data   <= '0;
            resp1_parity <= 1'b0;
            resp1_err    <= 1'b0;
        end else begin
            resp0_valid  <= w_hit0;
            resp0_data   <= (w_hit0 && !w_exit.illegal) ? dp_result : '0;
            resp0_parity <= w_hit0 && !w_exit.illegal && dp_parity;
            resp0_err    <= w_hit0 && (w_exit.illegal || w_par_err);
            resp1_valid  <= w_hit1;
            resp1_data   <= (w_hit1 && !w_exit.illegal) ? dp_result : '0;
            resp1_parity <= w_hit1 && !w_exit.illegal && dp_parity;
            resp1_err    <= w_hit1 && (w_exit.illegal || w_par_err);
        end
    end

    // Busy while anything is tracked between acceptance and tag exit.
    always_comb begin
        busy = r_issue_tag.valid || dp_valid;
        for (int i = 0; i < LATENCY; i++) begin
            busy = busy || r_tags[i].valid;
        end
    end

    // Saturating count of accepted transfers.
    always_ff @(posedge clock) begin
        if (reset) begin
            ops_count <= 8'd0;
        end else if (w_xfer && (ops_count != 8'hFF)) begin
            ops_count <= ops_count + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_issue_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pipe_issue_arbiter
// Brief    : Directed-vector bench with scoreboard queues and a decoupled
//            monitor for pipe_issue_arbiter (LATENCY=2). Honours
//            PARITY_CHECK_EN when defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_issue_arbiter;

    localparam int L = 2;
`ifdef PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    typedef struct packed {
        logic       v;
        logic [7:0] f;
        logic [3:0] a;
        logic [3:0] b;
    } op_t;

    typedef struct {
        logic [3:0] data;
        logic       parity;
        logic       err;
        int         cyc;
    } resp_t;

    typedef struct {
        logic [7:0] func;
        logic [3:0] a;
        logic [3:0] b;
        int         cyc;
    } dp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0] req0_func, req1_func;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       dp_valid;
    logic [7:0] dp_func;
    logic [3:0] dp_a, dp_b, dp_result;
    logic       dp_parity;
    logic       resp0_valid, resp0_parity, resp0_err;
    logic       resp1_valid, resp1_parity, resp1_err;
    logic [3:0] resp0_data, resp1_data;
    logic       busy;
    logic [7:0] ops_count;

    resp_t qr [2][$];
    dp_t   qd [$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    exp_ops  = 0;
    bit    mon_en   = 1'b0;
    bit    inject   = 1'b0;
    logic [3:0] hist [0:L];
    logic       hinj [0:L];

    pipe_issue_arbiter #(.LATENCY(L)) dut (
        .clock        (clock),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_func    (req0_func),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_func    (req1_func),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_ready   (req1_ready),
        .dp_valid     (dp_valid),
        .dp_func      (dp_func),
        .dp_a         (dp_a),
        .dp_b         (dp_b),
        .dp_result    (dp_result),
        .dp_parity    (dp_parity),
        .resp0_valid  (resp0_valid),
        .resp0_data   (resp0_data),
        .resp0_parity (resp0_parity),
        .resp0_err    (resp0_err),
        .resp1_valid  (resp1_valid),
        .resp1_data   (resp1_data),
        .resp1_parity (resp1_parity),
        .resp1_err    (resp1_err),
        .busy         (busy),
        .ops_count    (ops_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Datapath stand-in: result = a + b, presented L cycles after the issue cycle.
    always @(negedge clock) begin
        for (int i = L; i >= 1; i--) begin
            hist[i] = hist[i-1];
            hinj[i] = hinj[i-1];
        end
        hist[0]   = dp_a + dp_b;
        hinj[0]   = inject;
        dp_result = hist[L];
        dp_parity = (^hist[L]) ^ hinj[L];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard entry for an op the bench expects to be granted now.
    task automatic expect_op(input int id, input op_t o);
        resp_t      r;
        dp_t        d;
        logic       legal;
        logic [3:0] s;
        legal    = ($countones(o.f) == 1);
        s        = o.a + o.b;
        r.data   = legal ? s : 4'd0;
        r.parity = legal ? ((^s) ^ inject) : 1'b0;
        r.err    = !legal || (PCHK && inject);
        r.cyc    = cyc + L + 2;
        qr[id].push_back(r);
        if (legal) begin
            d.func = o.f;
            d.a    = o.a;
            d.b    = o.b;
            d.cyc  = cyc + 1;
            qd.push_back(d);
        end
        exp_ops = (exp_ops == 255) ? 255 : exp_ops + 1;
    endtask

    task automatic drive(input op_t o0, input op_t o1);
        req0_valid = o0.v; req0_func = o0.f; req0_a = o0.a; req0_b = o0.b;
        req1_valid = o1.v; req1_func = o1.f; req1_a = o1.a; req1_b = o1.b;
    endtask

    // One cycle of stimulus with the hand-expected grant vector {req1,req0}.
    task automatic step(input op_t o0, input op_t o1, input logic [1:0] eg);
        drive(o0, o1);
        @(negedge clock);
        chk("grant", {30'd0, req1_ready, req0_ready}, {30'd0, eg});
        if (eg[0]) expect_op(0, o0);
        if (eg[1]) expect_op(1, o1);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 2'b00);
    endtask

    task automatic mon_resp(input int id, input logic v, input logic [3:0] d,
                            input logic p, input logic e);
        resp_t r;
        if (v === 1'b1) begin
            if (qr[id].size() == 0) begin
                chk(id == 0 ? "resp0_unexpected" : "resp1_unexpected", {31'd0, v}, 32'd0);
            end else begin
                r = qr[id].pop_front();
                chk(id == 0 ? "resp0_cycle"  : "resp1_cycle",  cyc, r.cyc);
                chk(id == 0 ? "resp0_data"   : "resp1_data",   {28'd0, d}, {28'd0, r.data});
                chk(id == 0 ? "resp0_parity" : "resp1_parity", {31'd0, p}, {31'd0, r.parity});
                chk(id == 0 ? "resp0_err"    : "resp1_err",    {31'd0, e}, {31'd0, r.err});
            end
        end else begin
            chk(id == 0 ? "resp0_idle_zero" : "resp1_idle_zero", {26'd0, d, p, e}, 32'd0);
            if (qr[id].size() > 0 && qr[id][0].cyc <= cyc) begin
                chk(id == 0 ? "resp0_missing" : "resp1_missing", {31'd0, v}, 32'd1);
                void'(qr[id].pop_front());
            end
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard every cycle.
    always @(negedge clock) begin
        dp_t d;
        if (mon_en) begin
            if (dp_valid === 1'b1) begin
                if (qd.size() == 0) begin
                    chk("dp_unexpected", {31'd0, dp_valid}, 32'd0);
                end else begin
                    d = qd.pop_front();
                    chk("dp_cycle", cyc, d.cyc);
                    chk("dp_fields", {16'd0, dp_func, dp_a, dp_b}, {16'd0, d.func, d.a, d.b});
                end
            end else begin
                chk("dp_idle_zero", {16'd0, dp_func, dp_a, dp_b}, 32'd0);
                if (qd.size() > 0 && qd[0].cyc <= cyc) begin
                    chk("dp_missing", {31'd0, dp_valid}, 32'd1);
                    void'(qd.pop_front());
                end
            end
            mon_resp(0, resp0_valid, resp0_data, resp0_parity, resp0_err);
            mon_resp(1, resp1_valid, resp1_data, resp1_parity, resp1_err);
        end
    end

    initial begin
        op_t a0 [2];
        op_t a1 [2];
        int  k0, k1;
        for (int i = 0; i <= L; i++) begin
            hist[i] = 4'd0;
            hinj[i] = 1'b0;
        end
        drive('{1'b1, 8'h01, 4'd1, 4'd1}, '{1'b1, 8'h01, 4'd2, 4'd2});
        repeat (2) @(posedge clock);
        // Readies stay low while reset is high even with both requesting.
        @(negedge clock);
        chk("reset_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_ops_count", {24'd0, ops_count}, 32'd0);
        @(posedge clock);
        #1;
        drive('0, '0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Single legal op from requester 0: 3 + 4 = 7.
        step('{1'b1, 8'h01, 4'd3, 4'd4}, '0, 2'b01);
        idle(5);
        chk("ops_after_single", {24'd0, ops_count}, exp_ops);

        // Illegal two-hot function from requester 1.
        step('0, '{1'b1, 8'h03, 4'd5, 4'd6}, 2'b10);
        idle(5);

        // Both requesting for four cycles: grants alternate 0,1,0,1.
        a0[0] = '{1'b1, 8'h02, 4'd1, 4'd2};
        a0[1] = '{1'b1, 8'h10, 4'd6, 4'd6};
        a1[0] = '{1'b1, 8'h04, 4'd9, 4'd9};
        a1[1] = '{1'b1, 8'h80, 4'd15, 4'd1};
        k0 = 0;
        k1 = 0;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                step(a0[k0], a1[k1], 2'b01);
                k0++;
            end else begin
                step(a0[k0], a1[k1], 2'b10);
                k1++;
            end
        end
        idle(5);
        chk("ops_after_rr", {24'd0, ops_count}, exp_ops);

        // Corrupted parity on 4'b0111, then a clean one.
        inject = 1'b1;
        step('{1'b1, 8'h01, 4'd3, 4'd4}, '0, 2'b01);
        idle(1);
        inject = 1'b0;
        step('{1'b1, 8'h01, 4'd3, 4'd4}, '0, 2'b01);
        idle(5);

        // Two issues, then reset: in-flight ops are dropped, priority back to req0.
        step('0, '{1'b1, 8'h01, 4'd1, 4'd1}, 2'b10);
        step('{1'b1, 8'h02, 4'd2, 4'd2}, '0, 2'b01);
        reset = 1'b1;
        qr[0].delete();
        qr[1].delete();
        exp_ops = 0;
        drive('{1'b1, 8'h01, 4'd1, 4'd1}, '{1'b1, 8'h01, 4'd1, 4'd1});
        @(negedge clock);
        chk("reset_mid_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive('0, '0);
        @(negedge clock);
        chk("post_reset_busy", {31'd0, busy}, 32'd0);
        chk("post_reset_ops", {24'd0, ops_count}, 32'd0);
        @(posedge clock);
        #1;
        idle(4);
        step('{1'b1, 8'h08, 4'd4, 4'd4}, '{1'b1, 8'h08, 4'd5, 4'd5}, 2'b01);

        // 300 back-to-back transfers from requester 0.
        for (int i = 0; i < 300; i++) begin
            step('{1'b1, 8'(1 << (i % 8)), 4'(i), 4'(i >> 4)}, '0, 2'b01);
            if (i == 100) chk("ops_mid_stream", {24'd0, ops_count}, exp_ops);
        end
        idle(6);
        chk("ops_saturated", {24'd0, ops_count}, 32'd255);
        chk("final_busy", {31'd0, busy}, 32'd0);
        chk("queues_drained", qd.size() + qr[0].size() + qr[1].size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
